// File: rtl/conv_col_sequencer.sv
// Column sequencer for the 3x3 convolution kernel: buffers two previous rows,
// pushes one masked column per accepted pixel and two drain pushes per frame.
package conv_pkg;
    localparam int PIXEL_W           = 8;
    localparam int KERNEL_DIAMETER_N = 3;
    localparam int KERNEL_POS_W      = 4;

    typedef logic [PIXEL_W-1:0]                          pixel_t;
    typedef logic [KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0]   pixel_span_t;
    typedef logic [KERNEL_POS_W-1:0]                     kernel_pos_t;
endpackage

module conv_col_sequencer #(
    parameter int IMAGE_W = 16,
    parameter int IMAGE_H = 8
) (
    input  logic                                                      clk,
    input  logic                                                      arst_n,
    input  logic                                                      in_vld_i,
    input  logic [conv_pkg::PIXEL_W-1:0]                              in_dat_i,
    output logic                                                      in_rdy_o,
    output logic                                                      col_push_o,
    output logic [conv_pkg::KERNEL_DIAMETER_N-1:0]                    col_vld_o,
    output logic [conv_pkg::KERNEL_DIAMETER_N*conv_pkg::PIXEL_W-1:0]  col_dat_o,
    output logic [conv_pkg::KERNEL_POS_W-1:0]                         col_pos_o,
    output logic                                                      busy_o
);
    import conv_pkg::*;

    localparam int XW = $clog2(IMAGE_W);
    localparam int YW = $clog2(IMAGE_H);
    localparam int KD = KERNEL_DIAMETER_N;

    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] FLUSH0 = 2'd2;
    localparam logic [1:0] FLUSH1 = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    pixel_t lb1 [IMAGE_W];
    pixel_t lb0 [IMAGE_W];

    logic        accept;
    logic        row1_ok;
    logic        row2_ok;
    logic        sof;
    logic        sol;
    logic        eol;
    logic        eof;
    pixel_span_t col_nxt;
    kernel_pos_t pos_nxt;

    logic          col_push_p1;
    logic [KD-1:0] col_vld_p1;
    pixel_span_t   col_dat_p1;
    kernel_pos_t   col_pos_p1;

    function automatic pixel_t mask_row(input logic keep, input pixel_t pix);
        return keep ? pix : '0;
    endfunction

    function automatic kernel_pos_t pack_pos(input logic f_sof, input logic f_sol,
                                             input logic f_eol, input logic f_eof);
        return {f_eof, f_eol, f_sol, f_sof};
    endfunction

    assign in_rdy_o = (state == IDLE) || (state == ACTIVE);
    assign busy_o   = (state != IDLE);
    assign accept   = in_vld_i & in_rdy_o;

    always_comb begin
        row1_ok    = (y >= YW'(1));
        row2_ok    = (y >= YW'(2));
        sol        = (x == '0);
        sof        = sol && (y == '0);
        eol        = (x == X_LAST);
        eof        = eol && (y == Y_LAST);
        col_nxt    = '0;
        col_nxt[2] = in_dat_i;
        col_nxt[1] = mask_row(row1_ok, lb1[x]);
        col_nxt[0] = mask_row(row2_ok, lb0[x]);
        pos_nxt    = pack_pos(sof, sol, eol, eof);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = eof ? FLUSH0 : ACTIVE;
            ACTIVE:  if (accept && eof) state_nxt = FLUSH0;
            FLUSH0:  state_nxt = FLUSH1;
            FLUSH1:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: frame position counters and control state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (eol) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Line buffers shift one row down per accepted pixel; contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[x] <= lb1[x];
            lb1[x] <= in_dat_i;
        end
    end

    // p1: registered column push into the kernel stage
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_push_p1 <= 1'b0;
            col_vld_p1  <= '0;
            col_dat_p1  <= '0;
            col_pos_p1  <= '0;
        end else if (accept) begin
            col_push_p1 <= 1'b1;
            col_vld_p1  <= {1'b1, row1_ok, row2_ok};
            col_dat_p1  <= col_nxt;
            col_pos_p1  <= pos_nxt;
        end else begin
            col_push_p1 <= (state == FLUSH0) || (state == FLUSH1);
            col_vld_p1  <= '0;
            col_dat_p1  <= '0;
            col_pos_p1  <= '0;
        end
    end

    assign col_push_o = col_push_p1;
    assign col_vld_o  = col_vld_p1;
    assign col_dat_o  = col_dat_p1;
    assign col_pos_o  = col_pos_p1;

endmodule
